// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the MIPS instruction encoder and the control decoder.
// Holds the opcode and funct constants, the field-bundle kind/funct encodings,
// the loader state enum and the field-to-word encode function.
package instr_encoder_pkg;

   // Opcodes recognised by the single-cycle control decoder
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LUI   = 6'b001111;

   // R-type funct field values
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {
      KindR   = 3'd0,
      KindLw  = 3'd1,
      KindSw  = 3'd2,
      KindBeq = 3'd3,
      KindLui = 3'd4
   } kind_e;

   typedef enum logic [2:0] {
      FnAdd = 3'd0,
      FnSub = 3'd1,
      FnAnd = 3'd2,
      FnOr  = 3'd3,
      FnSlt = 3'd4
   } funct_e;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2
   } state_e;

   typedef struct packed {
      logic        legal;
      logic [31:0] word;
   } enc_t;

   // Builds the instruction word; legal=0 for unknown kinds or R functs.
   function automatic enc_t encode(input logic [2:0]  kind,
                                   input logic [2:0]  funct,
                                   input logic [4:0]  rs,
                                   input logic [4:0]  rt,
                                   input logic [4:0]  rd,
                                   input logic [15:0] imm);
      enc_t       e;
      logic [5:0] fn6;
      e.legal = 1'b1;
      e.word  = '0;
      fn6     = '0;
      case (kind)
         KindR: begin
            case (funct)
               FnAdd:   fn6 = FUNCT_ADD;
               FnSub:   fn6 = FUNCT_SUB;
               FnAnd:   fn6 = FUNCT_AND;
               FnOr:    fn6 = FUNCT_OR;
               FnSlt:   fn6 = FUNCT_SLT;
               default: e.legal = 1'b0;
            endcase
            e.word = {OP_RTYPE, rs, rt, rd, 5'b00000, fn6};
         end
         KindLw:  e.word = {OP_LW, rs, rt, imm};
         KindSw:  e.word = {OP_SW, rs, rt, imm};
         KindBeq: e.word = {OP_BEQ, rs, rt, imm};
         KindLui: e.word = {OP_LUI, 5'b00000, rt, imm};
         default: e.legal = 1'b0;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Bus bundle for the instruction encoder.
//   in_*  : decoded field bundle with valid/ready handshake (source -> encoder)
//   mem_* : instruction-memory write port with ready backpressure (encoder -> memory)
// Modport master is the program-source / memory side; slave is the encoder.
interface instr_encoder_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_kind;
   logic [2:0]        in_funct;
   logic [4:0]        in_rs;
   logic [4:0]        in_rt;
   logic [4:0]        in_rd;
   logic [15:0]       in_imm;
   logic              in_last;

   logic              mem_we;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (
      output in_valid, in_kind, in_funct, in_rs, in_rt, in_rd, in_imm, in_last, mem_ready,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in_valid, in_kind, in_funct, in_rs, in_rt, in_rd, in_imm, in_last, mem_ready,
      output in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/instr_encoder_sync_fifo.sv
// Synchronous FIFO with occupancy count.
//   clk, rst : clock, synchronous active-high reset
//   push/wdata : write (ignored when full)
//   pop/rdata  : read; rdata is the head entry, valid while count != 0
//   count, empty : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full, do_push, do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         count_q <= count_d;
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder / program loader.
// Encodes decoded field bundles into 32-bit words, queues them in a 4-entry FIFO
// and writes them to consecutive instruction-memory word addresses.
//   clk, rst  : clock, synchronous active-high reset
//   start     : begin a session (IDLE only); base_addr latched as write pointer
//   bus       : field-bundle handshake and memory write port (slave modport)
//   err       : one-cycle pulse, illegal bundle dropped
//   done      : one-cycle pulse, session fully written (first IDLE cycle)
//   busy      : session in progress
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   instr_encoder_if.slave    bus,
   output logic              err,
   output logic              done,
   output logic              busy
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic              err_q, err_d;
   logic              done_q, done_d;

   enc_t              enc;
   logic              accept, push, pop;
   logic [31:0]       fifo_rdata;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty;

   assign enc = encode(bus.in_kind, bus.in_funct, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm);

   assign bus.in_ready  = (state_q == StRun) && (fifo_count < CNT_W'(FIFO_DEPTH));
   assign accept        = bus.in_valid && bus.in_ready;
   // Illegal bundles complete the handshake but never enter the FIFO
   assign push          = accept && enc.legal;
   assign bus.mem_we    = !fifo_empty && (state_q != StIdle);
   assign pop           = bus.mem_we && bus.mem_ready;
   assign bus.mem_addr  = wptr_q;
   assign bus.mem_wdata = fifo_rdata;

   assign err  = err_q;
   assign done = done_q;
   assign busy = (state_q != StIdle);

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (enc.word),
      .pop   (pop),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      done_d  = 1'b0;
      err_d   = accept && !enc.legal;
      if (pop) wptr_d = wptr_q + ADDR_W'(1);
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               wptr_d  = base_addr;
            end
         end
         StRun: begin
            if (accept && bus.in_last) state_d = StDrain;
         end
         StDrain: begin
            if (fifo_empty) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         wptr_q  <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] base_addr = '0;
   logic       err, done, busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0]  wr_addr[$];
   logic [31:0] wr_data[$];
   int          wr_cyc[$];
   int          done_cnt = 0;
   int          err_cnt  = 0;

   instr_encoder_if #(.ADDR_W(8)) bus ();

   instr_encoder #(.ADDR_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .bus       (bus),
      .err       (err),
      .done      (done),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Write / pulse monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (bus.mem_we && bus.mem_ready) begin
         wr_addr.push_back(bus.mem_addr);
         wr_data.push_back(bus.mem_wdata);
         wr_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_session(input logic [7:0] base);
      start     = 1'b1;
      base_addr = base;
      tick();
      start     = 1'b0;
   endtask

   task automatic send(input logic [2:0] k, input logic [2:0] f, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                       input logic last);
      int n = 0;
      bus.in_kind  = k;
      bus.in_funct = f;
      bus.in_rs    = rs;
      bus.in_rt    = rt;
      bus.in_rd    = rd;
      bus.in_imm   = imm;
      bus.in_last  = last;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!bus.in_ready) begin
         bad++;
         $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
      end
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      int n = 0;
      while (done_cnt == d0 && n < 40) begin
         tick();
         n++;
      end
      total++;
      if (done_cnt == d0) begin
         bad++;
         $display("FAIL done_timeout: done pulses=%0d, required at least 1", done_cnt - d0);
      end
      repeat (3) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_kind = '0; bus.in_funct = '0; bus.in_rs = '0;
      bus.in_rt = '0; bus.in_rd = '0; bus.in_imm = '0; bus.in_last = 1'b0;
      bus.mem_ready = 1'b0;
      repeat (3) tick();
      total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %b req 0", bus.mem_we); end
      total++; if (bus.mem_addr !== 8'h00) begin bad++; $display("FAIL rst_mem_addr: got %h req 00", bus.mem_addr); end
      total++; if (bus.mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata: got %h req 0", bus.mem_wdata); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b req 0", bus.in_ready); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b req 0", err); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b req 0", done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b req 0", busy); end
      rst = 1'b0;
      tick();
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL idle_in_ready: got %b req 0", bus.in_ready); end
   endtask

   task automatic test_single();
      int n0 = wr_addr.size();
      int d0 = done_cnt;
      bus.mem_ready = 1'b1;
      start_session(8'h10);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b req 1", busy); end
      send(3'd1, 3'd0, 5'd0, 5'd8, 5'd0, 16'd4, 1'b1);
      wait_done(d0);
      total++; if (wr_addr.size() - n0 !== 1) begin bad++; $display("FAIL single_count: got %0d req 1", wr_addr.size() - n0); end
      total++; if (wr_addr[n0] !== 8'h10) begin bad++; $display("FAIL single_addr: got %h req 10", wr_addr[n0]); end
      total++; if (wr_data[n0] !== 32'h8C080004) begin bad++; $display("FAIL single_data: got %h req 8c080004", wr_data[n0]); end
      total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL single_done: got %0d req 1", done_cnt - d0); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: got busy=%b req 0", busy); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_w [4] = '{32'h00221820, 32'h3C011234, 32'hAC080008, 32'h1022FFFF};
      int n0 = wr_addr.size();
      int d0 = done_cnt;
      bus.mem_ready = 1'b1;
      start_session(8'h20);
      send(3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0);
      send(3'd4, 3'd0, 5'd5, 5'd1, 5'd9, 16'h1234, 1'b0);   // rs/rd must be ignored
      send(3'd2, 3'd0, 5'd0, 5'd8, 5'd31, 16'h0008, 1'b0);  // rd must be ignored
      send(3'd3, 3'd0, 5'd1, 5'd2, 5'd0, 16'hFFFF, 1'b1);
      wait_done(d0);
      total++; if (wr_addr.size() - n0 !== 4) begin bad++; $display("FAIL b2b_count: got %0d req 4", wr_addr.size() - n0); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (wr_data[n0+i] !== exp_w[i]) begin bad++; $display("FAIL b2b_data%0d: got %h req %h", i, wr_data[n0+i], exp_w[i]); end
         total++;
         if (wr_addr[n0+i] !== 8'(8'h20 + i)) begin bad++; $display("FAIL b2b_addr%0d: got %h req %h", i, wr_addr[n0+i], 8'(8'h20 + i)); end
         if (i > 0) begin
            total++;
            if (wr_cyc[n0+i] !== wr_cyc[n0] + i) begin bad++; $display("FAIL b2b_rate%0d: cycle %0d req %0d", i, wr_cyc[n0+i], wr_cyc[n0] + i); end
         end
      end
   endtask

   task automatic test_backpressure();
      int n0 = wr_addr.size();
      int d0 = done_cnt;
      int acc = 0;
      int n = 0;
      logic took;
      bus.mem_ready = 1'b0;
      start_session(8'h40);
      bus.in_kind = 3'd1; bus.in_funct = '0; bus.in_rs = '0; bus.in_rd = '0;
      bus.in_rt = 5'd0; bus.in_imm = 16'd0; bus.in_last = 1'b0; bus.in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         took = bus.in_ready;
         tick();
         if (took) begin
            acc++;
            bus.in_rt = 5'(acc); bus.in_imm = 16'(acc); bus.in_last = (acc == 5);
         end
      end
      total++; if (acc !== 4) begin bad++; $display("FAIL bp_accepted: got %0d req 4", acc); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b req 0", bus.in_ready); end
      total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL bp_mem_we: got %b req 1", bus.mem_we); end
      total++; if (bus.mem_addr !== 8'h40) begin bad++; $display("FAIL bp_addr_held: got %h req 40", bus.mem_addr); end
      total++; if (bus.mem_wdata !== 32'h8C000000) begin bad++; $display("FAIL bp_data_held: got %h req 8c000000", bus.mem_wdata); end
      total++; if (wr_addr.size() !== n0) begin bad++; $display("FAIL bp_no_write: got %0d writes req 0", wr_addr.size() - n0); end
      bus.mem_ready = 1'b1;
      while (acc < 6 && n < 40) begin
         took = bus.in_ready;
         tick();
         n++;
         if (took) begin
            acc++;
            bus.in_rt = 5'(acc); bus.in_imm = 16'(acc); bus.in_last = (acc == 5);
         end
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      wait_done(d0);
      total++; if (wr_addr.size() - n0 !== 6) begin bad++; $display("FAIL bp_count: got %0d req 6", wr_addr.size() - n0); end
      for (int i = 0; i < 6; i++) begin
         total++;
         if (wr_data[n0+i] !== {6'b100011, 5'd0, 5'(i), 16'(i)} || wr_addr[n0+i] !== 8'(8'h40 + i)) begin
            bad++;
            $display("FAIL bp_word%0d: got %h@%h req %h@%h", i, wr_data[n0+i], wr_addr[n0+i],
                     {6'b100011, 5'd0, 5'(i), 16'(i)}, 8'(8'h40 + i));
         end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_w [3] = '{32'h00221824, 32'h00221825, 32'h0022182A};
      logic [7:0]  exp_a [3] = '{8'hFE, 8'hFF, 8'h00};
      int n0 = wr_addr.size();
      int d0 = done_cnt;
      bus.mem_ready = 1'b1;
      start_session(8'hFE);
      send(3'd0, 3'd2, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
      send(3'd0, 3'd3, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
      send(3'd0, 3'd4, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1);
      wait_done(d0);
      total++; if (wr_addr.size() - n0 !== 3) begin bad++; $display("FAIL wrap_count: got %0d req 3", wr_addr.size() - n0); end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (wr_addr[n0+i] !== exp_a[i] || wr_data[n0+i] !== exp_w[i]) begin
            bad++;
            $display("FAIL wrap_word%0d: got %h@%h req %h@%h", i, wr_data[n0+i], wr_addr[n0+i], exp_w[i], exp_a[i]);
         end
      end
   endtask

   task automatic test_illegal();
      logic [31:0] exp_w [3] = '{32'h00221820, 32'h00221822, 32'h00221824};
      int n0 = wr_addr.size();
      int d0 = done_cnt;
      int e0 = err_cnt;
      bus.mem_ready = 1'b1;
      start_session(8'h80);
      send(3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
      send(3'd6, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
      send(3'd0, 3'd1, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
      send(3'd0, 3'd7, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
      send(3'd0, 3'd2, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1);
      wait_done(d0);
      total++; if (err_cnt - e0 !== 2) begin bad++; $display("FAIL ill_err: got %0d req 2", err_cnt - e0); end
      total++; if (wr_addr.size() - n0 !== 3) begin bad++; $display("FAIL ill_count: got %0d req 3", wr_addr.size() - n0); end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (wr_addr[n0+i] !== 8'(8'h80 + i) || wr_data[n0+i] !== exp_w[i]) begin
            bad++;
            $display("FAIL ill_word%0d: got %h@%h req %h@%h", i, wr_data[n0+i], wr_addr[n0+i], exp_w[i], 8'(8'h80 + i));
         end
      end
      total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL ill_done: got %0d req 1", done_cnt - d0); end
      // Illegal final bundle still ends the session
      n0 = wr_addr.size(); d0 = done_cnt; e0 = err_cnt;
      start_session(8'h90);
      send(3'd1, 3'd0, 5'd0, 5'd8, 5'd0, 16'd4, 1'b0);
      send(3'd7, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0, 1'b1);
      wait_done(d0);
      total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL ill_last_err: got %0d req 1", err_cnt - e0); end
      total++; if (wr_addr.size() - n0 !== 1 || wr_addr[n0] !== 8'h90) begin bad++; $display("FAIL ill_last_write: got %0d writes addr %h req 1 at 90", wr_addr.size() - n0, wr_addr[n0]); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ill_last_idle: got busy=%b req 0", busy); end
   endtask

   task automatic test_reset_mid();
      int n0 = wr_addr.size();
      int d0 = done_cnt;
      bus.mem_ready = 1'b0;
      start_session(8'h50);
      send(3'd1, 3'd0, 5'd0, 5'd1, 5'd0, 16'd1, 1'b0);
      send(3'd1, 3'd0, 5'd0, 5'd2, 5'd0, 16'd2, 1'b0);
      send(3'd1, 3'd0, 5'd0, 5'd3, 5'd0, 16'd3, 1'b0);
      total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL rmid_pending: got mem_we=%b req 1", bus.mem_we); end
      rst = 1'b1;
      tick();
      total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rmid_mem_we: got %b req 0", bus.mem_we); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b req 0", busy); end
      rst = 1'b0;
      bus.mem_ready = 1'b1;
      repeat (6) tick();
      total++; if (wr_addr.size() !== n0) begin bad++; $display("FAIL rmid_no_write: got %0d writes req 0", wr_addr.size() - n0); end
      total++; if (done_cnt !== d0) begin bad++; $display("FAIL rmid_no_done: got %0d pulses req 0", done_cnt - d0); end
      start_session(8'h60);
      send(3'd1, 3'd0, 5'd0, 5'd8, 5'd0, 16'h0022, 1'b1);
      wait_done(d0);
      total++; if (wr_addr.size() - n0 !== 1) begin bad++; $display("FAIL rmid_restart_count: got %0d req 1", wr_addr.size() - n0); end
      total++; if (wr_addr[n0] !== 8'h60 || wr_data[n0] !== 32'h8C080022) begin bad++; $display("FAIL rmid_restart_word: got %h@%h req 8c080022@60", wr_data[n0], wr_addr[n0]); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_wrap();
      test_illegal();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
